// File: rtl/des_block_uart_feeder.sv
// Serialises one 64-bit DES result block into bytes for the UART transmitter,
// MSB byte first, using its ready/start/done handshake.
//
// state | meaning
// IDLE  | waiting for i_fStart, block loaded on request
// SEND  | byte on o_TxData, o_fTx pulses once the transmitter is ready
// WAIT  | frame in flight, waiting for i_fTxDone
// GAP   | GAP_CYCLES idle cycles before the next byte
// DONE  | one-cycle o_fDone, then back to IDLE
module des_block_uart_feeder #(
   parameter int NUM_BYTES  = 8,
   parameter int GAP_CYCLES = 0
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_fStart,
   input  logic [63:0] i_Block,
   input  logic        i_fTxReady,
   input  logic        i_fTxDone,
   output logic        o_fTx,
   output logic [7:0]  o_TxData,
   output logic        o_fBusy,
   output logic        o_fDone
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEND = 3'd1,
      ST_WAIT = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [63:0]       shreg;
   logic [2:0]        byte_cnt;
   logic [GAP_W-1:0]  gap_cnt;

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         byte_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (i_fStart) begin
                  shreg    <= i_Block;
                  byte_cnt <= '0;
               end
            end
            ST_WAIT: begin
               // the last byte is never shifted out, so o_TxData holds it afterwards
               if (i_fTxDone && (byte_cnt != LAST_BYTE)) begin
                  shreg    <= {shreg[55:0], 8'h00};
                  byte_cnt <= byte_cnt + 3'd1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) gap_cnt <= '0;
               else                     gap_cnt <= gap_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (i_fStart) state_nxt = ST_SEND;
         ST_SEND: if (i_fTxReady) state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (i_fTxDone) begin
               if (byte_cnt == LAST_BYTE)  state_nxt = ST_DONE;
               else if (GAP_CYCLES > 0)    state_nxt = ST_GAP;
               else                        state_nxt = ST_SEND;
            end
         end
         ST_GAP:  if (gap_cnt == GAP_LAST) state_nxt = ST_SEND;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_fTx    = (state == ST_SEND) && i_fTxReady;
      o_TxData = shreg[63:56];
      o_fBusy  = (state != ST_IDLE);
      o_fDone  = (state == ST_DONE);
   end

endmodule
